bnn_cmd_decoder: RTL and testbench

//  Byte-stream command decoder at the front of the BNN accelerator's SPI path.

---
 rtl/bnn_cmd_decoder.sv | 166 ++++++++++++++++
 tb/tb_bnn_cmd_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_cmd_decoder.sv
// bnn_cmd_decoder
// Byte-stream command decoder at the front of the BNN accelerator's SPI path.
// An opcode byte in IDLE selects a load mode (inputs / weights / bias). The
// payload bytes that follow are forwarded on data_out with a one-cycle
// data_valid strobe. After the mode's byte count is reached, the decoder returns
// to IDLE. The current mode is reported one-hot on outs so that it can drive
// downstream write enables directly.
//
// Optional feature macro: DECODER_ABORT_EN
//   defined     : 0xAE received in a load state aborts to IDLE. The byte is not
//                 forwarded and the payload counter is cleared.
//   not defined : 0xAE in a load state is ordinary payload.
//
// Every output is registered. A response appears one clock after the cmd_valid
// sample that caused it.

module bnn_cmd_decoder #(
  parameter int N_INPUT_BYTES  = 1,
  parameter int N_WEIGHT_BYTES = 2,
  parameter int N_BIAS_BYTES   = 2,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  output logic [3:0] outs,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       err
);

  // Opcodes recognised in IDLE
  localparam logic [7:0] OP_INPUT  = 8'hB1;
  localparam logic [7:0] OP_WEIGHT = 8'hB2;
  localparam logic [7:0] OP_BIAS   = 8'hB3;
  localparam logic [7:0] OP_NOP    = 8'hAE;

  // One-hot mode codes presented on outs
  localparam logic [3:0] OH_IDLE   = 4'b0001;
  localparam logic [3:0] OH_INPUT  = 4'b0010;
  localparam logic [3:0] OH_WEIGHT = 4'b0100;
  localparam logic [3:0] OH_BIAS   = 4'b1000;

  // Payload lengths, resized to the counter width once so that compares stay width-matched
  localparam logic [CNT_W-1:0] N_IN_C  = CNT_W'(N_INPUT_BYTES);
  localparam logic [CNT_W-1:0] N_WT_C  = CNT_W'(N_WEIGHT_BYTES);
  localparam logic [CNT_W-1:0] N_BS_C  = CNT_W'(N_BIAS_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef DECODER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INPUT  = 2'd1,
    S_WEIGHT = 2'd2,
    S_BIAS   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_outs;
  logic [7:0]       r_data;
  logic             r_data_valid;
  logic             r_err;

  logic [CNT_W-1:0] w_target;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  logic             w_abort;

  // Select the payload length for the active load mode. IDLE's value is unused.
  always_comb begin
    w_target = N_IN_C;
    unique case (r_state)
      S_INPUT:  w_target = N_IN_C;
      S_WEIGHT: w_target = N_WT_C;
      S_BIAS:   w_target = N_BS_C;
      default:  w_target = N_IN_C;
    endcase
  end

  assign w_cnt_inc = r_cnt + CNT_ONE;
  // The byte being accepted now is the final byte of the payload
  assign w_last    = (w_cnt_inc == w_target);
  // The abort byte is only honoured when the feature is built in
  assign w_abort   = ABORT_EN && (cmd == OP_NOP);

  // Mode FSM with registered outputs. Strobes default low and pulse for one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_outs       <= OH_IDLE;
      r_data       <= 8'h00;
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
      if (cmd_valid) begin
        unique case (r_state)
          S_IDLE: begin
            // Every opcode starts a fresh payload count
            r_cnt <= '0;
            unique case (cmd)
              OP_INPUT: begin
                r_state <= S_INPUT;
                r_outs  <= OH_INPUT;
              end
              OP_WEIGHT: begin
                r_state <= S_WEIGHT;
                r_outs  <= OH_WEIGHT;
              end
              OP_BIAS: begin
                r_state <= S_BIAS;
                r_outs  <= OH_BIAS;
              end
              OP_NOP: begin
                r_err <= 1'b0;
              end
              default: begin
                r_err <= 1'b1;
              end
            endcase
          end
          default: begin
            if (w_abort) begin
              // The abort byte is swallowed: nothing is forwarded
              r_state <= S_IDLE;
              r_outs  <= OH_IDLE;
              r_cnt   <= '0;
            end else begin
              // Payload is raw data. Opcode values are not decoded here.
              r_data       <= cmd;
              r_data_valid <= 1'b1;
              if (w_last) begin
                // outs drops to IDLE in the same cycle as the final data_valid
                r_state <= S_IDLE;
                r_outs  <= OH_IDLE;
                r_cnt   <= '0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
        endcase
      end
    end
  end

  assign outs       = r_outs;
  assign data_out   = r_data;
  assign data_valid = r_data_valid;
  assign err        = r_err;

  // Structural invariants of the output encoding
  a_outs_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot(outs));
  a_err_idle    : assert property (@(posedge clk) disable iff (!rst_n) err |-> (outs == OH_IDLE));
  a_err_no_data : assert property (@(posedge clk) disable iff (!rst_n) !(err && data_valid));

endmodule

// File: tb/tb_bnn_cmd_decoder.sv
// tb_bnn_cmd_decoder
// Each step pushes the expected output sample to exp_q and drives one cycle. It
// then captures the DUT outputs into obs_q one time unit after the rising edge.
// Every scenario task pops both queues and compares the samples itself.

module tb_bnn_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [3:0] outs;
  logic [7:0] data_out;
  logic       data_valid;
  logic       err;

  typedef struct packed {
    logic [3:0] outs;
    logic       dv;
    logic [7:0] data;
    logic       err;
  } smp_t;

  smp_t exp_q[$];
  smp_t obs_q[$];
  logic [7:0] exp_hold;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bnn_cmd_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .outs       (outs),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err        (err)
  );

  function automatic smp_t sample();
    smp_t s;
    s = {outs, data_valid, data_out, err};
    return s;
  endfunction

  // Drive one cycle and record what the DUT must show one clock later.
  // data_out must equal the byte when data_valid is expected, and must otherwise hold.
  task automatic step(input logic v, input logic [7:0] b, input logic [3:0] eo,
                      input logic edv, input logic ee);
    smp_t e;
    if (edv) exp_hold = b;
    e = {eo, edv, exp_hold, ee};
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = v;
    cmd       = b;
    @(posedge clk);
    #1;
    obs_q.push_back(sample());
  endtask

  task automatic test_reset();
    smp_t e, o;
    int idx = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 8'h00; exp_hold = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({4'b0001, 1'b0, 8'h00, 1'b0});
    obs_q.push_back(sample());
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got outs=%b dv=%b data=%h err=%b, expected outs=%b dv=%b data=%h err=%b",
                 idx, o.outs, o.dv, o.data, o.err, e.outs, e.dv, e.data, e.err);
      end
      idx++;
    end
  endtask

  task automatic test_weight_load();
    smp_t e, o;
    int idx = 0;
    step(1'b1, 8'hB2, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 8'hDF, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 8'h00, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL weight_load[%0d]: got outs=%b dv=%b data=%h err=%b, expected outs=%b dv=%b data=%h err=%b",
                 idx, o.outs, o.dv, o.data, o.err, e.outs, e.dv, e.data, e.err);
      end
      idx++;
    end
  endtask

  task automatic test_bad_opcode();
    smp_t e, o;
    int idx = 0;
    step(1'b1, 8'h07, 4'b0001, 1'b0, 1'b1);
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 8'hAE, 4'b0001, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bad_opcode[%0d]: got outs=%b dv=%b data=%h err=%b, expected outs=%b dv=%b data=%h err=%b",
                 idx, o.outs, o.dv, o.data, o.err, e.outs, e.dv, e.data, e.err);
      end
      idx++;
    end
  endtask

  task automatic test_raw_payload();
    smp_t e, o;
    int idx = 0;
    step(1'b1, 8'hB1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 8'hB3, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL raw_payload[%0d]: got outs=%b dv=%b data=%h err=%b, expected outs=%b dv=%b data=%h err=%b",
                 idx, o.outs, o.dv, o.data, o.err, e.outs, e.dv, e.data, e.err);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid_load();
    smp_t e, o;
    int idx = 0;
    step(1'b1, 8'hB3, 4'b1000, 1'b0, 1'b0);
    step(1'b1, 8'h11, 4'b1000, 1'b1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    exp_hold = 8'h00;
    #1;
    // The reset is asynchronous, so outputs are checked before the next rising edge
    exp_q.push_back({4'b0001, 1'b0, 8'h00, 1'b0});
    obs_q.push_back(sample());
    @(negedge clk);
    rst_n = 1'b1;
    // The partial payload is gone. The next byte is decoded as an (unknown) opcode.
    step(1'b1, 8'h22, 4'b0001, 1'b0, 1'b1);
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_load[%0d]: got outs=%b dv=%b data=%h err=%b, expected outs=%b dv=%b data=%h err=%b",
                 idx, o.outs, o.dv, o.data, o.err, e.outs, e.dv, e.data, e.err);
      end
      idx++;
    end
  endtask

  task automatic test_abort();
    smp_t e, o;
    int idx = 0;
    step(1'b1, 8'hB2, 4'b0100, 1'b0, 1'b0);
`ifdef DECODER_ABORT_EN
    step(1'b1, 8'hAE, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 8'h55, 4'b0001, 1'b0, 1'b1);
`else
    step(1'b1, 8'hAE, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 8'h55, 4'b0001, 1'b1, 1'b0);
`endif
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort[%0d]: got outs=%b dv=%b data=%h err=%b, expected outs=%b dv=%b data=%h err=%b",
                 idx, o.outs, o.dv, o.data, o.err, e.outs, e.dv, e.data, e.err);
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    smp_t e, o;
    int idx = 0;
    step(1'b1, 8'hB1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 8'h7E, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 8'hB2, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 8'hB1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 8'hB3, 4'b1000, 1'b0, 1'b0);
    step(1'b1, 8'h00, 4'b1000, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 8'hAE, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 8'hB1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got outs=%b dv=%b data=%h err=%b, expected outs=%b dv=%b data=%h err=%b",
                 idx, o.outs, o.dv, o.data, o.err, e.outs, e.dv, e.data, e.err);
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_bad_opcode();
    test_raw_payload();
    test_reset_mid_load();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // The sequence is fixed-length. This only guards against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule
